// File: rtl/gen_pkg.sv
// Purpose: shared definitions for the generator sequencer slice.
//   - gen_state_e : sequencer FSM state encoding
//   - SRC_F/SRC_T : out_src encoding (which generator produced the word)
//   - DATA_W_DEF/CNT_W_DEF : default word and counter widths
package gen_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int CNT_W_DEF  = 16;

  localparam logic SRC_F = 1'b0;
  localparam logic SRC_T = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN_F = 3'd1,
    ST_RUN_T = 3'd2,
    ST_DRAIN = 3'd3,
    ST_CLEAR = 3'd4
  } gen_state_e;

endpackage : gen_pkg

// File: rtl/out_slot.sv
// Purpose: one-entry ready/valid output register. A load captures data/src and
//   raises valid; the entry is held stable while valid & !ready and is released
//   when ready is seen. A load may coincide with a release (back-to-back words).
// Ports:
//   clock, reset      : clock and synchronous active-high reset
//   load              : capture data_in/src_in this edge (caller guarantees room)
//   data_in, src_in   : word and its source tag
//   ready             : downstream accepts the current entry
//   valid, data, src  : registered entry
module out_slot
  import gen_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load,
  input  logic [DATA_W-1:0] data_in,
  input  logic              src_in,
  input  logic              ready,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic              src
);

  logic              valid_r;
  logic [DATA_W-1:0] data_r;
  logic              src_r;

  // Entry register: load wins over release; reset discards any pending word.
  always_ff @(posedge clock) begin
    if (reset) begin
      valid_r <= 1'b0;
      data_r  <= '0;
      src_r   <= 1'b0;
    end else if (load) begin
      valid_r <= 1'b1;
      data_r  <= data_in;
      src_r   <= src_in;
    end else if (valid_r && ready) begin
      valid_r <= 1'b0;
    end else begin
      valid_r <= valid_r;
    end
  end

  assign valid = valid_r;
  assign data  = data_r;
  assign src   = src_r;

endmodule : out_slot

// File: rtl/gen_seq_ctrl.sv
// Purpose: sequencer/arbiter between the Fibonacci (F) and timer (T) generators
//   and the shared output path. Latches prog into prog_cfg, grants one generator
//   at a time, forwards its words through a one-entry output register, then
//   drains and issues a single clear pulse before returning to idle.
// Ports:
//   clock, reset            : clock, synchronous active-high reset
//   start_f/start_t/stop_f_t: one-cycle control pulses
//   update, prog            : load request and requested configuration
//   f_valid/f_data/f_done   : Fibonacci generator interface
//   t_valid/t_data/t_done   : timer generator interface
//   out_ready               : downstream ready
//   en_f/en_t, ack_f/ack_t  : generator enables and word acknowledges
//   clr_gen                 : clear pulse to both generators
//   prog_cfg                : latched configuration
//   out_valid/out_data/out_src : output word
//   word_cnt                : words forwarded in the current run (saturating)
//   LED                     : {prog_cfg, upd_rej, run_t, run_f}
module gen_seq_ctrl
  import gen_pkg::*;
#(
  parameter int         DATA_W   = DATA_W_DEF,
  parameter int         CNT_W    = CNT_W_DEF,
  parameter logic [2:0] PROG_RST = 3'd3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start_f,
  input  logic              start_t,
  input  logic              stop_f_t,
  input  logic              update,
  input  logic [2:0]        prog,
  input  logic              f_valid,
  input  logic [DATA_W-1:0] f_data,
  input  logic              t_valid,
  input  logic [DATA_W-1:0] t_data,
  input  logic              f_done,
  input  logic              t_done,
  input  logic              out_ready,
  output logic              en_f,
  output logic              en_t,
  output logic              ack_f,
  output logic              ack_t,
  output logic              clr_gen,
  output logic [2:0]        prog_cfg,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_src,
  output logic [CNT_W-1:0]  word_cnt,
  output logic [5:0]        LED
);

  gen_state_e        state_r;
  gen_state_e        state_s;
  logic [2:0]        prog_cfg_r;
  logic              upd_rej_r;
  logic [CNT_W-1:0]  word_cnt_r;

  logic              en_f_s;
  logic              en_t_s;
  logic              ack_f_s;
  logic              ack_t_s;
  logic              clr_gen_s;
  logic              run_f_s;
  logic              run_t_s;
  logic              load_s;
  logic [DATA_W-1:0] load_data_s;
  logic              load_src_s;
  logic              out_valid_s;
  logic              room_s;
  logic              start_any_s;

  // Room in the output slot: empty, or its word leaves this cycle.
  assign room_s      = !out_valid_s || out_ready;
  assign start_any_s = start_f || start_t;

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; start_f has priority over start_t.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start_f) begin
          state_s = ST_RUN_F;
        end else if (start_t) begin
          state_s = ST_RUN_T;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RUN_F: begin
        if (stop_f_t || f_done) begin
          state_s = ST_DRAIN;
        end else begin
          state_s = ST_RUN_F;
        end
      end
      ST_RUN_T: begin
        if (stop_f_t || t_done) begin
          state_s = ST_DRAIN;
        end else begin
          state_s = ST_RUN_T;
        end
      end
      ST_DRAIN: begin
        if (!out_valid_s) begin
          state_s = ST_CLEAR;
        end else begin
          state_s = ST_DRAIN;
        end
      end
      ST_CLEAR: state_s = ST_IDLE;
      default:  state_s = ST_IDLE;
    endcase
  end

  // Outputs decoded from state; a word acked on the stop/done cycle still loads.
  always_comb begin
    en_f_s    = 1'b0;
    en_t_s    = 1'b0;
    ack_f_s   = 1'b0;
    ack_t_s   = 1'b0;
    run_f_s   = 1'b0;
    run_t_s   = 1'b0;
    clr_gen_s = reset;
    case (state_r)
      ST_RUN_F: begin
        en_f_s  = 1'b1;
        run_f_s = 1'b1;
        ack_f_s = f_valid && room_s;
      end
      ST_RUN_T: begin
        en_t_s  = 1'b1;
        run_t_s = 1'b1;
        ack_t_s = t_valid && room_s;
      end
      ST_CLEAR: clr_gen_s = 1'b1;
      ST_IDLE:  clr_gen_s = reset;
      ST_DRAIN: clr_gen_s = reset;
      default:  clr_gen_s = reset;
    endcase
  end

  // Select the word presented to the output slot.
  always_comb begin
    load_s      = ack_f_s || ack_t_s;
    load_data_s = f_data;
    load_src_s  = SRC_F;
    if (ack_t_s) begin
      load_data_s = t_data;
      load_src_s  = SRC_T;
    end else begin
      load_data_s = f_data;
      load_src_s  = SRC_F;
    end
  end

  // Configuration latch: updates are accepted only in IDLE, rejected otherwise.
  always_ff @(posedge clock) begin
    if (reset) begin
      prog_cfg_r <= PROG_RST;
      upd_rej_r  <= 1'b0;
    end else if (update) begin
      if (state_r == ST_IDLE) begin
        prog_cfg_r <= prog;
        upd_rej_r  <= 1'b0;
      end else begin
        upd_rej_r  <= 1'b1;
      end
    end else begin
      upd_rej_r <= upd_rej_r;
    end
  end

  // Forwarded-word counter: cleared on run entry, saturates at all-ones.
  always_ff @(posedge clock) begin
    if (reset) begin
      word_cnt_r <= '0;
    end else if ((state_r == ST_IDLE) && start_any_s) begin
      word_cnt_r <= '0;
    end else if (load_s && !(&word_cnt_r)) begin
      word_cnt_r <= word_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      word_cnt_r <= word_cnt_r;
    end
  end

  out_slot #(
    .DATA_W (DATA_W)
  ) u_out_slot (
    .clock   (clock),
    .reset   (reset),
    .load    (load_s),
    .data_in (load_data_s),
    .src_in  (load_src_s),
    .ready   (out_ready),
    .valid   (out_valid_s),
    .data    (out_data),
    .src     (out_src)
  );

  assign en_f      = en_f_s;
  assign en_t      = en_t_s;
  assign ack_f     = ack_f_s;
  assign ack_t     = ack_t_s;
  assign clr_gen   = clr_gen_s;
  assign prog_cfg  = prog_cfg_r;
  assign out_valid = out_valid_s;
  assign word_cnt  = word_cnt_r;
  assign LED       = {prog_cfg_r, upd_rej_r, run_t_s, run_f_s};

endmodule : gen_seq_ctrl

// File: tb/tb_gen_seq_ctrl.sv
module tb_gen_seq_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start_f = 1'b0, start_t = 1'b0, stop_f_t = 1'b0, update = 1'b0;
  logic [2:0]  prog = 3'd0;
  logic        f_valid = 1'b0, t_valid = 1'b0, f_done = 1'b0, t_done = 1'b0;
  logic [15:0] f_data = 16'd0, t_data = 16'd0;
  logic        out_ready = 1'b0;
  logic        en_f, en_t, ack_f, ack_t, clr_gen, out_valid, out_src;
  logic [2:0]  prog_cfg;
  logic [15:0] out_data, word_cnt;
  logic [5:0]  LED;

  int errors = 0;
  int checks = 0;

  gen_seq_ctrl dut (
    .clock(clock), .reset(reset), .start_f(start_f), .start_t(start_t),
    .stop_f_t(stop_f_t), .update(update), .prog(prog),
    .f_valid(f_valid), .f_data(f_data), .t_valid(t_valid), .t_data(t_data),
    .f_done(f_done), .t_done(t_done), .out_ready(out_ready),
    .en_f(en_f), .en_t(en_t), .ack_f(ack_f), .ack_t(ack_t), .clr_gen(clr_gen),
    .prog_cfg(prog_cfg), .out_valid(out_valid), .out_data(out_data),
    .out_src(out_src), .word_cnt(word_cnt), .LED(LED)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    // 1: reset and configuration updates in IDLE
    tick();
    chk("rst_clr_gen", clr_gen, 1);
    chk("rst_out_valid", out_valid, 0);
    tick();
    reset = 1'b0;
    #1;
    chk("rst_clr_gen_drop", clr_gen, 0);
    chk("rst_led", LED, 6'b011000);
    chk("rst_word_cnt", word_cnt, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_en", {en_f, en_t}, 0);
    prog = 3'd6; update = 1'b1;
    tick();
    update = 1'b0;
    chk("upd6_prog_cfg", prog_cfg, 6);
    prog = 3'd3; update = 1'b1;
    tick();
    update = 1'b0;
    chk("upd3_prog_cfg", prog_cfg, 3);
    chk("upd3_led_hi", LED[5:3], 3);
    chk("upd3_rej", LED[2], 0);

    // 2: timer run of five words, then done
    start_t = 1'b1;
    tick();
    start_t = 1'b0;
    chk("t_run_en", {en_f, en_t}, 2'b01);
    chk("t_run_led", LED[1:0], 2'b10);
    chk("t_run_cnt", word_cnt, 0);
    out_ready = 1'b1; t_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      t_data = 16'h0100 + 16'(i);
      #1;
      chk("t_ack", ack_t, 1);
      tick();
      chk("t_out_valid", out_valid, 1);
      chk("t_out_data", out_data, 32'h0100 + i);
      chk("t_out_src", out_src, 1);
      chk("t_word_cnt", word_cnt, i + 1);
    end
    t_valid = 1'b0; t_done = 1'b1;
    tick();
    t_done = 1'b0;
    chk("t_drain_en", en_t, 0);
    chk("t_drain_led", LED[1:0], 0);
    chk("t_drain_valid", out_valid, 0);
    chk("t_drain_clr", clr_gen, 0);
    chk("t_drain_cnt", word_cnt, 5);
    tick();
    chk("t_clear_pulse", clr_gen, 1);
    tick();
    chk("t_idle_clr", clr_gen, 0);
    chk("t_idle_en", {en_f, en_t}, 0);

    // 3: simultaneous starts with an update; start_f wins, new prog used
    prog = 3'd2; update = 1'b1; start_f = 1'b1; start_t = 1'b1;
    tick();
    update = 1'b0; start_f = 1'b0; start_t = 1'b0;
    chk("both_led", LED[1:0], 2'b01);
    chk("both_en", {en_f, en_t}, 2'b10);
    chk("both_prog_cfg", prog_cfg, 2);
    chk("both_cnt", word_cnt, 0);
    start_t = 1'b1;
    tick();
    start_t = 1'b0;
    chk("midrun_start_t", {en_f, en_t}, 2'b10);

    // 4: backpressure, resume, then stop with a held word
    out_ready = 1'b0; f_valid = 1'b1; f_data = 16'hA001;
    #1;
    chk("bp_first_ack", ack_f, 1);
    tick();
    chk("bp_first_data", out_data, 16'hA001);
    chk("bp_first_cnt", word_cnt, 1);
    f_data = 16'hA002;
    for (int i = 0; i < 4; i++) begin
      chk("bp_no_ack", ack_f, 0);
      tick();
      chk("bp_hold_data", out_data, 16'hA001);
      chk("bp_hold_valid", out_valid, 1);
    end
    chk("bp_hold_cnt", word_cnt, 1);
    out_ready = 1'b1;
    #1;
    chk("bp_resume_ack", ack_f, 1);
    tick();
    chk("bp_resume_data", out_data, 16'hA002);
    f_data = 16'hA003;
    tick();
    chk("bp_nobubble_data", out_data, 16'hA003);
    chk("bp_nobubble_cnt", word_cnt, 3);
    out_ready = 1'b0; f_valid = 1'b0; stop_f_t = 1'b1;
    tick();
    stop_f_t = 1'b0;
    chk("stop_en_f", en_f, 0);
    chk("stop_led", LED[1:0], 0);
    chk("stop_held_valid", out_valid, 1);
    chk("stop_held_data", out_data, 16'hA003);
    tick();
    chk("drain_wait_valid", out_valid, 1);
    chk("drain_wait_clr", clr_gen, 0);
    out_ready = 1'b1;
    tick();
    chk("drain_taken", out_valid, 0);
    chk("drain_taken_clr", clr_gen, 0);
    tick();
    chk("f_clear_pulse", clr_gen, 1);
    tick();
    chk("f_idle_clr", clr_gen, 0);

    // 5: update rejected during a run, accepted back in IDLE
    start_t = 1'b1;
    tick();
    start_t = 1'b0;
    prog = 3'd5; update = 1'b1;
    tick();
    update = 1'b0;
    chk("rej_prog_cfg", prog_cfg, 2);
    chk("rej_flag", LED[2], 1);
    stop_f_t = 1'b1;
    tick();
    stop_f_t = 1'b0;
    tick();
    tick();
    chk("rej_idle_led", LED[2:0], 3'b100);
    update = 1'b1;
    tick();
    update = 1'b0;
    chk("rej_cleared_prog", prog_cfg, 5);
    chk("rej_cleared_flag", LED[2], 0);

    // 6: reset in the middle of an F run with a pending word
    start_f = 1'b1;
    tick();
    start_f = 1'b0;
    out_ready = 1'b0; f_valid = 1'b1; f_data = 16'hBEEF;
    tick();
    chk("mid_valid", out_valid, 1);
    chk("mid_en_f", en_f, 1);
    reset = 1'b1;
    tick();
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_en_f", en_f, 0);
    chk("mid_rst_ack_f", ack_f, 0);
    chk("mid_rst_prog", prog_cfg, 3);
    chk("mid_rst_led", LED[1:0], 0);
    chk("mid_rst_clr", clr_gen, 1);
    reset = 1'b0; f_valid = 1'b0;
    #1;
    chk("mid_rst_clr_drop", clr_gen, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_gen_seq_ctrl
